// File: rtl/rw_sched_pkg.sv
// rtl/rw_sched_pkg.sv - shared types and defaults for the ReWire context scheduler
package rw_sched_pkg;

    localparam int               CTX_W_DEFAULT     = 2;
    localparam logic [1:0]       CTX_RESET_DEFAULT = 2'b00;
    localparam int               NREQ_DEFAULT      = 4;
    localparam int               RR_W_DEFAULT      = $clog2(NREQ_DEFAULT);

    // Resumption context of the generated core: {resumption tag, state bit}.
    typedef struct packed {
        logic tag;
        logic st;
    } ctx_t;

    typedef logic [RR_W_DEFAULT-1:0] rr_ptr_t;

endpackage

// File: rtl/rw_rr_arbiter.sv
// rtl/rw_rr_arbiter.sv - combinational round-robin arbiter starting at ptr
module rw_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    int j;

    // Scan from farthest to nearest so the closest request to ptr wins last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        j         = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                grant     = '0;
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/rw_ctx_scheduler.sv
// rtl/rw_ctx_scheduler.sv - time-multiplexes one ReWire step core among NREQ saved contexts
module rw_ctx_scheduler
    import rw_sched_pkg::*;
#(
    parameter int               NREQ      = 4,
    parameter int               IN_W      = 1,
    parameter int               OUT_W     = 1,
    parameter int               CTX_W     = CTX_W_DEFAULT,
    parameter logic [CTX_W-1:0] CTX_RESET = CTX_W'(CTX_RESET_DEFAULT),
    parameter int               STEP_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pause,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*IN_W-1:0]      req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [NREQ*OUT_W-1:0]     rsp_data,
    output logic [NREQ-1:0]           rsp_last,
    output logic [NREQ-1:0]           halted,
    input  logic [NREQ-1:0]           ctx_clear,
    output logic [IN_W-1:0]           dev_in,
    output logic [CTX_W-1:0]          dev_ctx,
    input  logic [OUT_W-1:0]          dev_out,
    input  logic [CTX_W-1:0]          dev_ctx_next,
    input  logic                      dev_continue,
    input  logic [$clog2(NREQ)-1:0]   stat_sel,
    output logic [STEP_W-1:0]         stat_count
);

    localparam int IDX_W = $clog2(NREQ);

    logic [CTX_W-1:0]  ctx   [NREQ];
    logic [STEP_W-1:0] count [NREQ];
    logic [IDX_W-1:0]  rr_ptr;
    logic [NREQ-1:0]   elig;
    logic [NREQ-1:0]   grant;
    logic [IDX_W-1:0]  g;
    logic              grant_any;

    // A context being cleared is never eligible, so clear and step cannot collide.
    assign elig      = req_valid & ~halted & ~ctx_clear & {NREQ{~pause & ~rst}};
    assign grant_any = |grant;
    assign req_ready = grant;

    rw_rr_arbiter #(
        .N  (NREQ),
        .IW (IDX_W)
    ) u_arb (
        .req       (elig),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (g)
    );

    always_comb begin
        dev_in  = '0;
        dev_ctx = ctx[rr_ptr];
        if (grant_any) begin
            dev_in  = req_data[g*IN_W +: IN_W];
            dev_ctx = ctx[g];
        end
    end

    assign stat_count = count[stat_sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            rsp_valid <= '0;
            rsp_last  <= '0;
            rsp_data  <= '0;
            halted    <= '0;
            for (int i = 0; i < NREQ; i++) begin
                ctx[i]   <= CTX_RESET;
                count[i] <= '0;
            end
        end else begin
            rsp_valid <= grant;
            rsp_last  <= grant & {NREQ{~dev_continue}};
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i]) begin
                    ctx[i]                       <= dev_ctx_next;
                    rsp_data[i*OUT_W +: OUT_W]   <= dev_out;
                    halted[i]                    <= ~dev_continue;
                    if (count[i] != '1) begin
                        count[i] <= count[i] + 1'b1;
                    end
                end else if (ctx_clear[i]) begin
                    ctx[i]    <= CTX_RESET;
                    halted[i] <= 1'b0;
                    count[i]  <= '0;
                end
            end
            if (grant_any) begin
                rr_ptr <= (int'(g) == NREQ - 1) ? '0 : g + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rw_ctx_scheduler.sv
// tb/tb_rw_ctx_scheduler.sv - directed self-checking bench for rw_ctx_scheduler
module tb_rw_ctx_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause = 1'b0;
    logic [3:0] req_valid = '0;
    logic [3:0] req_data = '0;
    logic [3:0] ctx_clear = '0;
    logic [1:0] stat_sel = '0;
    logic       kill2 = 1'b0;
    logic [3:0] req_ready, rsp_valid, rsp_data, rsp_last, halted;
    logic       dev_in, dev_out, dev_continue;
    logic [1:0] dev_ctx, dev_ctx_next;
    logic [3:0] stat_count;

    int checks = 0;
    int errors = 0;

    logic [3:0] tab [8] = '{4'b1010, 4'b0110, 4'b1111, 4'b0001,
                            4'b1100, 4'b0011, 4'b1001, 4'b0101};
    int         g3 [13] = '{0, 1, 2, 3, 0, 1, 3, 0, 1, 3, 0, 1, 3};
    logic [1:0] mctx [4];
    logic [3:0] mdata;
    logic       b;
    int         e;

    always #5 clk = ~clk;

    // Generated core: out = in, next context = {in, in}.
    assign dev_out      = dev_in;
    assign dev_ctx_next = {dev_in, dev_in};
    assign dev_continue = ~(kill2 & req_ready[2]);

    rw_ctx_scheduler #(
        .NREQ   (4),
        .IN_W   (1),
        .OUT_W  (1),
        .CTX_W  (2),
        .STEP_W (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pause        (pause),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_last     (rsp_last),
        .halted       (halted),
        .ctx_clear    (ctx_clear),
        .dev_in       (dev_in),
        .dev_ctx      (dev_ctx),
        .dev_out      (dev_out),
        .dev_ctx_next (dev_ctx_next),
        .dev_continue (dev_continue),
        .stat_sel     (stat_sel),
        .stat_count   (stat_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stat(input int sel, input int exp);
        stat_sel = 2'(sel);
        #1;
        check($sformatf("stat_count[%0d]", sel), 32'(stat_count), 32'(exp));
    endtask

    initial begin
        req_valid = 4'hF;
        repeat (2) tick();
        check("rst_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_last", rsp_last, 0);
        check("rst_halted", halted, 0);
        stat(0, 0);

        // Single requester after reset release
        rst = 1'b0; req_valid = 4'b0001; req_data = 4'b0001;
        #1;
        check("t1_ready", req_ready, 4'b0001);
        check("t1_dev_in", dev_in, 1);
        check("t1_dev_ctx", dev_ctx, 2'b00);
        tick();
        check("t1_rsp_valid", rsp_valid, 4'b0001);
        check("t1_rsp_data", rsp_data, 4'b0001);
        check("t1_rsp_last", rsp_last, 0);
        stat(0, 1);
        req_data = 4'b0000;
        #1;
        check("t1_ctx_saved", dev_ctx, 2'b11);
        check("t1_ready2", req_ready, 4'b0001);
        tick();
        check("t1_rsp_data2", rsp_data, 4'b0000);
        req_valid = 4'b0000;
        #1;
        check("idle_ready", req_ready, 0);
        check("idle_dev_in", dev_in, 0);
        tick();
        check("idle_rsp_valid", rsp_valid, 0);
        stat(0, 2);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        stat(0, 0);

        // Full contention, round-robin from rr_ptr = 0
        mdata = '0;
        for (int i = 0; i < 4; i++) mctx[i] = 2'b00;
        for (int c = 0; c < 8; c++) begin
            e = c % 4;
            req_valid = 4'hF; req_data = tab[c];
            #1;
            check($sformatf("rr_ready[%0d]", c), req_ready, 4'b0001 << e);
            check($sformatf("rr_ctx[%0d]", c), dev_ctx, mctx[e]);
            tick();
            b = tab[c][e];
            mdata[e] = b; mctx[e] = {b, b};
            check($sformatf("rr_valid[%0d]", c), rsp_valid, 4'b0001 << e);
            check($sformatf("rr_data[%0d]", c), rsp_data, mdata);
        end
        for (int i = 0; i < 4; i++) stat(i, 2);

        // Requester 2 halts; others keep being served
        kill2 = 1'b1;
        for (int c = 0; c < 13; c++) begin
            e = g3[c];
            req_data = tab[(c + 3) % 8];
            #1;
            check($sformatf("h_ready[%0d]", c), req_ready, 4'b0001 << e);
            check($sformatf("h_ctx[%0d]", c), dev_ctx, mctx[e]);
            tick();
            b = req_data[e];
            mdata[e] = b; mctx[e] = {b, b};
            check($sformatf("h_valid[%0d]", c), rsp_valid, 4'b0001 << e);
            check($sformatf("h_data[%0d]", c), rsp_data, mdata);
            if (e == 2) begin
                check("h_last", rsp_last, 4'b0100);
                check("h_halted", halted, 4'b0100);
            end
        end
        check("h_halted_end", halted, 4'b0100);
        check("h_last_end", rsp_last, 0);

        kill2 = 1'b0; ctx_clear = 4'b0100;
        #1;
        check("clr_ready", req_ready, 4'b0001);
        tick();
        ctx_clear = '0;
        check("clr_halted", halted, 0);
        req_valid = 4'b0100; req_data = 4'b0100;
        #1;
        check("clr_regrant", req_ready, 4'b0100);
        check("clr_ctx", dev_ctx, 2'b00);
        tick();
        check("clr_rsp_valid", rsp_valid, 4'b0100);
        check("clr_rsp_last", rsp_last, 0);
        check("clr_halted2", halted, 0);
        stat(2, 1);

        // Pause: in-flight response delivered, grants resume at saved pointer
        req_valid = 4'hF; req_data = 4'hF;
        #1;
        check("p_ready_pre", req_ready, 4'b1000);
        tick();
        pause = 1'b1;
        #1;
        check("p_inflight", rsp_valid, 4'b1000);
        check("p_ready0", req_ready, 0);
        tick();
        check("p_valid1", rsp_valid, 0);
        check("p_ready1", req_ready, 0);
        tick();
        check("p_valid2", rsp_valid, 0);
        check("p_ready2", req_ready, 0);
        tick();
        pause = 1'b0;
        #1;
        check("p_resume", req_ready, 4'b0001);
        tick();
        check("p_resume_valid", rsp_valid, 4'b0001);

        // Reset right after a grant drops the pending response
        #1;
        check("r_ready", req_ready, 4'b0010);
        tick();
        check("r_pulse", rsp_valid, 4'b0010);
        rst = 1'b1;
        #1;
        check("r_ready_rst", req_ready, 0);
        tick();
        check("r_valid", rsp_valid, 0);
        check("r_data", rsp_data, 0);
        check("r_halted", halted, 0);
        rst = 1'b0; req_valid = 4'hF; req_data = 4'b0001;
        #1;
        check("r_ready_after", req_ready, 4'b0001);
        check("r_ctx_reset", dev_ctx, 2'b00);
        tick();
        check("r_step_data", rsp_data, 4'b0001);
        req_valid = '0;
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        tick();
        check("glitch_data", rsp_data, 4'b0001);
        check("glitch_valid", rsp_valid, 0);
        stat(0, 1);
        stat(3, 0);

        // Counter saturation on requester 1
        req_valid = 4'b0010;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (n == 13) stat(1, 14);
        end
        req_valid = '0;
        stat(1, 15);
        ctx_clear = 4'b0010;
        tick();
        ctx_clear = '0;
        stat(1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
